// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: 2-bit saturating counter, tag and target per entry,
// registered lookup with read-before-write against same-cycle updates, plus a misprediction counter.
module branch_predictor #(
    parameter int unsigned ENTRIES = 64
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        pred_valid_i,
    input  logic [31:0] pred_pc_i,
    output logic        pred_valid_o,
    output logic        pred_taken_o,
    output logic [31:0] pred_target_o,
    input  logic        upd_valid_i,
    input  logic [31:0] upd_pc_i,
    input  logic        upd_taken_i,
    input  logic [31:0] upd_target_i,
    input  logic        upd_pred_taken_i,
    output logic [31:0] mispredict_cnt_o
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 30 - IDX_W;

    logic [1:0]       ctr    [ENTRIES];
    logic             valid  [ENTRIES];
    logic [TAG_W-1:0] tag    [ENTRIES];
    logic [29:0]      target [ENTRIES];

    logic [IDX_W-1:0] pred_idx;
    logic [TAG_W-1:0] pred_tag;
    logic             lookup_hit;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_match;
    logic [1:0]       upd_ctr;

    assign pred_idx = pred_pc_i[IDX_W+1:2];
    assign pred_tag = pred_pc_i[31:IDX_W+2];
    assign upd_idx  = upd_pc_i[IDX_W+1:2];
    assign upd_tag  = upd_pc_i[31:IDX_W+2];

    // Lookup reads the table as it stands before this cycle's update lands.
    assign lookup_hit = pred_valid_i && valid[pred_idx]
                        && (tag[pred_idx] == pred_tag) && ctr[pred_idx][1];

    assign upd_match = (tag[upd_idx] == upd_tag);

    // New counter value: re-seed on a tag change, otherwise saturate toward the outcome.
    always_comb begin
        upd_ctr = ctr[upd_idx];
        if (!upd_match) begin
            upd_ctr = upd_taken_i ? 2'd2 : 2'd1;
        end else if (upd_taken_i) begin
            if (ctr[upd_idx] != 2'd3) upd_ctr = ctr[upd_idx] + 2'd1;
        end else begin
            if (ctr[upd_idx] != 2'd0) upd_ctr = ctr[upd_idx] - 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                ctr[i]    <= 2'd1;
                valid[i]  <= 1'b0;
                tag[i]    <= '0;
                target[i] <= '0;
            end
        end else if (upd_valid_i) begin
            ctr[upd_idx] <= upd_ctr;
            if (upd_taken_i) begin
                valid[upd_idx]  <= 1'b1;
                tag[upd_idx]    <= upd_tag;
                target[upd_idx] <= upd_target_i[31:2];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pred_valid_o     <= 1'b0;
            pred_taken_o     <= 1'b0;
            pred_target_o    <= '0;
            mispredict_cnt_o <= '0;
        end else begin
            pred_valid_o  <= pred_valid_i;
            pred_taken_o  <= lookup_hit;
            pred_target_o <= lookup_hit ? {target[pred_idx], 2'b00} : 32'd0;
            if (upd_valid_i && (upd_pred_taken_i != upd_taken_i))
                mispredict_cnt_o <= mispredict_cnt_o + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural table model.
module tb_branch_predictor;

    localparam int unsigned ENTRIES = 64;
    localparam int unsigned IDX_W   = 6;

    logic        clk = 1'b0;
    logic        reset_i = 1'b0;
    logic        pred_valid_i = 1'b0;
    logic [31:0] pred_pc_i = '0;
    logic        pred_valid_o, pred_taken_o;
    logic [31:0] pred_target_o;
    logic        upd_valid_i = 1'b0;
    logic [31:0] upd_pc_i = '0;
    logic        upd_taken_i = 1'b0;
    logic [31:0] upd_target_i = '0;
    logic        upd_pred_taken_i = 1'b0;
    logic [31:0] mispredict_cnt_o;

    branch_predictor #(.ENTRIES(ENTRIES)) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .pred_valid_i    (pred_valid_i),
        .pred_pc_i       (pred_pc_i),
        .pred_valid_o    (pred_valid_o),
        .pred_taken_o    (pred_taken_o),
        .pred_target_o   (pred_target_o),
        .upd_valid_i     (upd_valid_i),
        .upd_pc_i        (upd_pc_i),
        .upd_taken_i     (upd_taken_i),
        .upd_target_i    (upd_target_i),
        .upd_pred_taken_i(upd_pred_taken_i),
        .mispredict_cnt_o(mispredict_cnt_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    endtask

    // Reference model: one record per table slot, arithmetic on plain ints.
    int          m_ctr [ENTRIES];
    bit          m_vld [ENTRIES];
    int unsigned m_tag [ENTRIES];
    logic [31:0] m_tgt [ENTRIES];
    logic [31:0] m_cnt;
    logic        e_valid, e_taken;
    logic [31:0] e_target;

    function automatic int unsigned idx_of(input logic [31:0] pc);
        return (pc >> 2) % ENTRIES;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return pc >> (IDX_W + 2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(ENTRIES); i++) begin
            m_ctr[i] = 1; m_vld[i] = 0; m_tag[i] = 0; m_tgt[i] = '0;
        end
        m_cnt = '0;
    endtask

    // One clock: drive inputs, predict from the pre-update model, then advance the model.
    task automatic do_cycle(input bit rst, input bit pv, input logic [31:0] ppc,
                            input bit uv, input logic [31:0] upc, input bit ut,
                            input logic [31:0] utgt, input bit upt);
        int unsigned i;
        reset_i = rst; pred_valid_i = pv; pred_pc_i = ppc;
        upd_valid_i = uv; upd_pc_i = upc; upd_taken_i = ut;
        upd_target_i = utgt; upd_pred_taken_i = upt;
        if (rst) begin
            e_valid = 0; e_taken = 0; e_target = '0;
            model_reset();
        end else begin
            i = idx_of(ppc);
            e_valid  = pv;
            e_taken  = pv && m_vld[i] && (m_tag[i] == tag_of(ppc)) && (m_ctr[i] >= 2);
            e_target = e_taken ? m_tgt[i] : 32'd0;
            if (uv) begin
                i = idx_of(upc);
                if (m_tag[i] != tag_of(upc)) m_ctr[i] = ut ? 2 : 1;
                else if (ut) m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                else         m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                if (ut) begin
                    m_vld[i] = 1; m_tag[i] = tag_of(upc); m_tgt[i] = utgt & 32'hFFFF_FFFC;
                end
                if (upt != ut) m_cnt = m_cnt + 32'd1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check("pred_valid",  32'(pred_valid_o),  32'(e_valid));
        check("pred_taken",  32'(pred_taken_o),  32'(e_taken));
        check("pred_target", pred_target_o,      e_target);
        check("mispredict",  mispredict_cnt_o,   m_cnt);
    endtask

    task automatic idle_rst();
        do_cycle(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic lookup(input logic [31:0] pc);
        do_cycle(0, 1, pc, 0, 0, 0, 0, 0);
    endtask

    task automatic update(input logic [31:0] pc, input bit t, input logic [31:0] tgt, input bit pt);
        do_cycle(0, 0, 0, 1, pc, t, tgt, pt);
    endtask

    logic [31:0] rpc, rupc;

    initial begin
        // Reset with traffic presented; nothing may be retained.
        do_cycle(1, 1, 32'h100, 1, 32'h100, 1, 32'h200, 0);
        idle_rst();
        check("rst_valid", 32'(pred_valid_o), 32'd0);
        check("rst_cnt",   mispredict_cnt_o,  32'd0);

        // Cold lookup.
        lookup(32'h100);
        check("cold_valid",  32'(pred_valid_o), 32'd1);
        check("cold_taken",  32'(pred_taken_o), 32'd0);
        check("cold_target", pred_target_o,     32'd0);

        // Training.
        update(32'h100, 1, 32'h200, 0);
        lookup(32'h100);
        check("train_taken",  32'(pred_taken_o), 32'd1);
        check("train_target", pred_target_o,     32'h200);

        // Saturation.
        idle_rst();
        repeat (4) update(32'h100, 1, 32'h200, 1);
        update(32'h100, 0, 32'h0, 1);
        lookup(32'h100);
        check("sat_still_taken", 32'(pred_taken_o), 32'd1);
        repeat (2) update(32'h100, 0, 32'h0, 1);
        lookup(32'h100);
        check("sat_not_taken", 32'(pred_taken_o), 32'd0);
        update(32'h100, 1, 32'h200, 0);
        update(32'h100, 1, 32'h200, 0);
        lookup(32'h100);
        check("sat_retrain", 32'(pred_taken_o), 32'd1);

        // Aliasing at one index with two tags.
        idle_rst();
        repeat (2) update(32'h100, 1, 32'h200, 1);
        update(32'h200, 1, 32'h300, 0);
        lookup(32'h100);
        check("alias_old", 32'(pred_taken_o), 32'd0);
        lookup(32'h200);
        check("alias_new_taken",  32'(pred_taken_o), 32'd1);
        check("alias_new_target", pred_target_o,     32'h300);

        // Same-cycle lookup and update: lookup sees the old entry.
        idle_rst();
        do_cycle(0, 1, 32'h40, 1, 32'h40, 1, 32'h80, 0);
        check("rbw_same", 32'(pred_taken_o), 32'd0);
        lookup(32'h40);
        check("rbw_next",   32'(pred_taken_o), 32'd1);
        check("rbw_target", pred_target_o,     32'h80);

        // Misprediction counter and reset clearing it.
        idle_rst();
        update(32'h10, 1, 32'h20, 0);
        update(32'h14, 0, 32'h0,  1);
        update(32'h18, 1, 32'h24, 1);
        update(32'h1C, 1, 32'h28, 0);
        update(32'h10, 0, 32'h0,  0);
        check("cnt_three", mispredict_cnt_o, 32'd3);
        idle_rst();
        check("cnt_cleared", mispredict_cnt_o, 32'd0);

        // Randomized traffic over a few indices and tags to force aliasing.
        for (int n = 0; n < 600; n++) begin
            rpc  = {22'($urandom_range(0, 3)), 2'b00, 6'($urandom_range(0, 7)), 2'($urandom)};
            rupc = {22'($urandom_range(0, 3)), 2'b00, 6'($urandom_range(0, 7)), 2'($urandom)};
            if (($urandom % 4) == 0) rupc = rpc;
            do_cycle(($urandom % 64) == 0, 1'($urandom), rpc, 1'($urandom), rupc,
                     1'($urandom), $urandom, 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
